// File: rtl/ext_pulse_pkg.sv
// Shared types and defaults for the D15 burst pulse generator.
package ext_pulse_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_TIM_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // A programmed length of zero still yields a one-cycle phase.
    function automatic logic [DEF_TIM_W-1:0] phase_len(input logic [DEF_TIM_W-1:0] x);
        return (x == '0) ? DEF_TIM_W'(1) : x;
    endfunction

endpackage

// File: rtl/ext_pulse_gen_if.sv
// Host-side request/status bundle for ext_pulse_gen.
// abort_i exists only when EXT_PULSE_ABORT_EN is defined.
interface ext_pulse_gen_if
    import ext_pulse_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int TIM_W = DEF_TIM_W
);
    logic             start_i;
    logic [CNT_W-1:0] count_i;
    logic [TIM_W-1:0] high_cycles_i;
    logic [TIM_W-1:0] low_cycles_i;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] pulses_sent_o;
`ifdef EXT_PULSE_ABORT_EN
    logic             abort_i;
`endif

    modport master (
`ifdef EXT_PULSE_ABORT_EN
        output abort_i,
`endif
        output start_i, count_i, high_cycles_i, low_cycles_i,
        input  busy_o, done_o, pulses_sent_o
    );

    modport slave (
`ifdef EXT_PULSE_ABORT_EN
        input  abort_i,
`endif
        input  start_i, count_i, high_cycles_i, low_cycles_i,
        output busy_o, done_o, pulses_sent_o
    );

endinterface

// File: rtl/ext_phase_timer.sv
// Reloadable down-counter timing both the HIGH and LOW phases.
module ext_phase_timer #(
    parameter int TIM_W = 16
) (
    input  logic             CLK_IN,
    input  logic             RESET_N_i,
    input  logic             load_i,
    input  logic [TIM_W-1:0] len_i,
    output logic             expire_o
);
    logic [TIM_W-1:0] cnt_q, cnt_d;

    // len_i is never zero, so len_i-1 cannot wrap even at the maximum value.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = len_i - TIM_W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TIM_W'(1);
        end
    end

    always_ff @(posedge CLK_IN or negedge RESET_N_i) begin
        if (!RESET_N_i) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/ext_pulse_gen.sv
// Burst pulse generator driving pin D15_o with N pulses of H high / L low cycles.
// Optional abort input enabled by defining EXT_PULSE_ABORT_EN.
module ext_pulse_gen
    import ext_pulse_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int TIM_W = DEF_TIM_W
) (
    input  logic           CLK_IN,
    input  logic           RESET_N_i,
    ext_pulse_gen_if.slave bus,
    output logic           D15_o
);
    state_t           state_q;
    logic [CNT_W-1:0] count_q, sent_q;
    logic [TIM_W-1:0] h_len_q, l_len_q;
    logic             first_q, busy_q, done_q, d15_q;
    logic             abort_w, accept_w, more_w, tmr_load_w, tmr_expire_w;
    logic [TIM_W-1:0] h_in_w, l_in_w, tmr_len_w;

`ifdef EXT_PULSE_ABORT_EN
    assign abort_w = bus.abort_i;
`else
    assign abort_w = 1'b0;
`endif

    assign accept_w = (state_q == IDLE) && bus.start_i;
    assign more_w   = (sent_q < count_q);
    assign h_in_w   = TIM_W'(phase_len(DEF_TIM_W'(bus.high_cycles_i)));
    assign l_in_w   = TIM_W'(phase_len(DEF_TIM_W'(bus.low_cycles_i)));

    always_comb begin
        tmr_load_w = 1'b0;
        tmr_len_w  = h_len_q;
        unique case (state_q)
            IDLE: begin
                tmr_load_w = accept_w && (bus.count_i != '0);
                tmr_len_w  = h_in_w;
            end
            HIGH: begin
                tmr_load_w = tmr_expire_w;
                tmr_len_w  = l_len_q;
            end
            LOW: begin
                tmr_load_w = tmr_expire_w && more_w;
                tmr_len_w  = h_len_q;
            end
            default: ;
        endcase
    end

    ext_phase_timer #(.TIM_W(TIM_W)) u_timer (
        .CLK_IN    (CLK_IN),
        .RESET_N_i (RESET_N_i),
        .load_i    (tmr_load_w),
        .len_i     (tmr_len_w),
        .expire_o  (tmr_expire_w)
    );

    always_ff @(posedge CLK_IN or negedge RESET_N_i) begin
        if (!RESET_N_i) begin
            state_q <= IDLE;
            count_q <= '0;
            sent_q  <= '0;
            h_len_q <= TIM_W'(1);
            l_len_q <= TIM_W'(1);
            first_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d15_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // The edge counter is bumped at the end of each pulse's first high cycle.
            if (first_q) begin
                first_q <= 1'b0;
                if (sent_q < count_q) sent_q <= sent_q + CNT_W'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        count_q <= bus.count_i;
                        h_len_q <= h_in_w;
                        l_len_q <= l_in_w;
                        sent_q  <= '0;
                        if (bus.count_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= HIGH;
                            d15_q   <= 1'b1;
                            busy_q  <= 1'b1;
                            first_q <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (abort_w) begin
                        state_q <= IDLE;
                        d15_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (tmr_expire_w) begin
                        state_q <= LOW;
                        d15_q   <= 1'b0;
                    end
                end
                LOW: begin
                    if (abort_w || (tmr_expire_w && !more_w)) begin
                        state_q <= IDLE;
                        d15_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (tmr_expire_w) begin
                        state_q <= HIGH;
                        d15_q   <= 1'b1;
                        first_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign D15_o             = d15_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.pulses_sent_o = sent_q;

endmodule
